request_unit: RTL
=================

# request_unit

Sequential companion to the instruction decoder in the single-cycle MIPS datapath. It consumes the decoder's memory-request and halt outputs, the cache or memory controller's `ihit` and `dhit` strobes, and sequences the instruction fetch and data access. It generates the stall and advance enables for the PC and the register file. It keeps the halt sticky, so the CPU stops cleanly after the `HALT` opcode.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles to wait for `dhit`. Used only with `REQ_TIMEOUT_EN`.
- `CNT_W`, default 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports (name, direction, width, meaning):
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `cu_dREN`  in  1  decoder requests a data read (LW).
- `cu_dWEN`  in  1  decoder requests a data write (SW).
- `cu_halt`  in  1  decoder sees the HALT opcode.
- `ihit`  in  1  instruction word valid this cycle.
- `dhit`  in  1  data access completes this cycle.
- `imemREN`  out  1  instruction fetch request.
- `dmemREN`  out  1  data read request, registered.
- `dmemWEN`  out  1  data write request, registered.
- `pc_en`  out  1  PC loads its next value this cycle.
- `rf_wen_en`  out  1  qualifies the register-file write enable; equals `pc_en`.
- `halt`  out  1  sticky halt, registered.
- `req_timeout`  out  1  sticky dhit-timeout error. Exists only with `REQ_TIMEOUT_EN`.

## Operation
The FSM has three states.
- **FETCH**
  - `imemREN`=1.
  - On `ihit` with `cu_halt`=1: go to HALTED. `halt` is set at the same edge; `pc_en`=0.
  - On `ihit` with (`cu_dREN`|`cu_dWEN`)=1: go to DATA and latch the request bits. `pc_en`=0.
  - On `ihit` with neither: stay in FETCH. `pc_en`=1.
  - With no `ihit`: stay in FETCH. `pc_en`=0.
  - `dhit` is ignored in FETCH.
- **DATA**
  - `imemREN`=0.
  - `dmemREN`/`dmemWEN` hold the latched request bits.
  - On `dhit`: `pc_en`=1 that cycle, then go to FETCH; the request bits clear at the same edge.
- **HALTED**
  - All requests are 0; `pc_en`=0; `halt`=1.
  - Exit is only by `RST`.

Request priority and encoding:
- If `cu_dREN` and `cu_dWEN` are both 1 when latching, `dmemWEN` wins and `dmemREN` latches 0.
- `cu_halt` has priority over a memory request in the same fetch.

Reset:
- `RST`=1 on any edge forces FETCH.
- Every registered output is 0 after reset: `dmemREN`, `dmemWEN`, `halt`, `req_timeout`.
- Combinational outputs then follow FETCH: `imemREN`=1, `pc_en`=`ihit`.
- A reset during DATA drops `dmemREN`/`dmemWEN` at that edge, even if `dhit` is high.

## Timing
- `imemREN` and `pc_en` are combinational from state, `ihit`, `dhit` and the `cu_*` inputs.
- `dmemREN`, `dmemWEN`, `halt` and `req_timeout` are flops.
- Load or store latency: the fetch hit cycle N, then data requests are asserted from cycle N+1 until `dhit`. `pc_en` pulses in the `dhit` cycle.
  - Minimum: 2 cycles per LW/SW (ihit at N, dhit at N+1).
  - ALU instructions: 1 cycle when `ihit` is held high.
- The decoder inputs stay stable throughout DATA because the PC does not advance. The latched copy is authoritative anyway.
- `rf_wen_en` equals `pc_en`, so a load writes the register file only in the `dhit` cycle.

## Configuration
- `REQ_TIMEOUT_EN` defined:
  - A `CNT_W`-bit counter clears on entry to DATA and increments each DATA cycle without `dhit`.
  - When the counter reaches `TIMEOUT_CYCLES`: set `req_timeout`, drop the data requests, and go to HALTED with `halt`=1.
  - `req_timeout` clears only on `RST`.
- `REQ_TIMEOUT_EN` undefined: no counter and no `req_timeout` port. DATA waits for `dhit` indefinitely.

## Structure
- A state enum `reqstate_t` (FETCH, DATA, HALTED) is added to `cpu_types_pkg`.
- An interface `request_unit_if` with `ru` and `tb` modports matches the `control_unit_if` style.
- No sub-module; the timeout counter is inline under the macro.

## Test plan
1. Reset: hold `RST` for 2 cycles with `ihit`=1. Required after release: `dmemREN`=`dmemWEN`=`halt`=0, `imemREN`=1, `pc_en`=1.
2. LW: `cu_dREN`=1 with `ihit` at cycle 0, and `dhit` at cycle 3.
   - `dmemREN`=1 for cycles 1–3; `imemREN`=0 for cycles 1–3.
   - `pc_en`=1 only in cycle 3; FETCH in cycle 4.
3. SW with both request bits set: `cu_dREN`=`cu_dWEN`=1 and `dhit` at cycle 1.
   - Only `dmemWEN`=1, in cycle 1.
   - `pc_en` pulses in cycle 1.
4. HALT: `cu_halt`=1 with `ihit`.
   - `halt`=1 from the next cycle and stays 1 over 10 cycles of random `ihit`/`dhit`.
   - `pc_en` and all requests stay 0.
5. Reset mid-DATA: `RST` at the second DATA cycle with `dhit`=1.
   - Requests are 0 next cycle; the FSM is in FETCH.
   - No `pc_en` pulse from `dhit`.
6. `REQ_TIMEOUT_EN` with `TIMEOUT_CYCLES`=4: issue an LW and never assert `dhit`.
   - `req_timeout`=1 and `halt`=1 after 4 DATA cycles, with `dmemREN`=0.
   - Without the macro, `dmemREN` stays 1 for 50 cycles.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared types for the single-cycle MIPS datapath control.
//   reqstate_t : request_unit sequencing state
//     FETCH  - instruction fetch outstanding, waiting for ihit
//     DATA   - latched load/store outstanding, waiting for dhit
//     HALTED - HALT retired; only reset leaves this state
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } reqstate_t;

endpackage

// File: rtl/request_unit_if.sv
// request_unit_if
//   Signal bundle between the request unit and its neighbours, in the same
//   style as control_unit_if.
//   ru modport : the request unit's view (decoder/cache strobes in, enables out)
//   tb modport : the driving side's view (the mirror image)
//   Optional feature macro: REQ_TIMEOUT_EN adds req_timeout.
interface request_unit_if;
  import cpu_types_pkg::*;

  logic cu_dREN;
  logic cu_dWEN;
  logic cu_halt;
  logic ihit;
  logic dhit;
  logic imemREN;
  logic dmemREN;
  logic dmemWEN;
  logic pc_en;
  logic rf_wen_en;
  logic halt;
`ifdef REQ_TIMEOUT_EN
  logic req_timeout;
`endif
  reqstate_t fsm_state;

  modport ru (
    input  cu_dREN, cu_dWEN, cu_halt, ihit, dhit,
`ifdef REQ_TIMEOUT_EN
    output req_timeout,
`endif
    output imemREN, dmemREN, dmemWEN, pc_en, rf_wen_en, halt, fsm_state
  );

  modport tb (
    output cu_dREN, cu_dWEN, cu_halt, ihit, dhit,
`ifdef REQ_TIMEOUT_EN
    input  req_timeout,
`endif
    input  imemREN, dmemREN, dmemWEN, pc_en, rf_wen_en, halt, fsm_state
  );

endinterface

// File: rtl/request_unit.sv
// request_unit
//   Sequences instruction fetch and data access for the single-cycle MIPS
//   datapath, produces the PC / register-file advance enable and keeps the
//   HALT sticky.
//
//   Ports:
//     CLK, RST            clock (rising edge), synchronous active-high reset
//     cu_dREN/cu_dWEN     decoder load / store request
//     cu_halt             decoder sees HALT
//     ihit, dhit          instruction word valid / data access complete
//     imemREN             fetch request (combinational)
//     dmemREN/dmemWEN     latched data request (registered)
//     pc_en, rf_wen_en    advance enables (combinational, identical)
//     halt                sticky halt (registered)
//     req_timeout         sticky dhit-timeout error (REQ_TIMEOUT_EN only)
//     fsm_state           current FSM state, for observation
//
//   Handshake: ihit and dhit are single-cycle completion strobes; a request
//   is held asserted until its strobe is seen high at a rising edge, and the
//   strobe is only honoured in the state that owns that request.
//
//   Optional feature macro: REQ_TIMEOUT_EN adds the TIMEOUT_CYCLES / CNT_W
//   parameters, the DATA wait counter and the req_timeout output.
//   CNT_W must satisfy 2**CNT_W > TIMEOUT_CYCLES.
module request_unit
  import cpu_types_pkg::*;
`ifdef REQ_TIMEOUT_EN
  #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
  )
`endif
  (
  input  logic      CLK,
  input  logic      RST,
  input  logic      cu_dREN,
  input  logic      cu_dWEN,
  input  logic      cu_halt,
  input  logic      ihit,
  input  logic      dhit,
  output logic      imemREN,
  output logic      dmemREN,
  output logic      dmemWEN,
  output logic      pc_en,
  output logic      rf_wen_en,
  output logic      halt,
`ifdef REQ_TIMEOUT_EN
  output logic      req_timeout,
`endif
  output reqstate_t fsm_state
);

  reqstate_t state;
  reqstate_t state_next;
  logic      dren_next;
  logic      dwen_next;
  logic      halt_next;

`ifdef REQ_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             timeout_next;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= FETCH;
      dmemREN <= 1'b0;
      dmemWEN <= 1'b0;
      halt    <= 1'b0;
`ifdef REQ_TIMEOUT_EN
      cnt         <= '0;
      req_timeout <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      dmemREN <= dren_next;
      dmemWEN <= dwen_next;
      halt    <= halt_next;
`ifdef REQ_TIMEOUT_EN
      cnt         <= cnt_next;
      req_timeout <= timeout_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    imemREN    = 1'b0;
    pc_en      = 1'b0;
    dren_next  = dmemREN;
    dwen_next  = dmemWEN;
    halt_next  = halt;
`ifdef REQ_TIMEOUT_EN
    cnt_next     = cnt;
    timeout_next = req_timeout;
`endif
    case (state)
      FETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          if (cu_halt) begin
            // HALT outranks any memory request decoded from the same word.
            state_next = HALTED;
            halt_next  = 1'b1;
          end else if (cu_dREN | cu_dWEN) begin
            state_next = DATA;
            // A word claiming both read and write is treated as a store.
            dwen_next  = cu_dWEN;
            dren_next  = cu_dREN & ~cu_dWEN;
`ifdef REQ_TIMEOUT_EN
            cnt_next   = '0;
`endif
          end else begin
            // The PC must not move while reset is being applied.
            pc_en = ~RST;
          end
        end
      end
      DATA: begin
        if (dhit) begin
          pc_en      = ~RST;
          state_next = FETCH;
          dren_next  = 1'b0;
          dwen_next  = 1'b0;
        end
`ifdef REQ_TIMEOUT_EN
        // cnt counts completed miss cycles, so the give-up point is the
        // cycle in which it would reach TIMEOUT_CYCLES.
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_next   = HALTED;
          dren_next    = 1'b0;
          dwen_next    = 1'b0;
          halt_next    = 1'b1;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
`endif
      end
      HALTED: begin
        dren_next = 1'b0;
        dwen_next = 1'b0;
        halt_next = 1'b1;
      end
      default: begin
        state_next = FETCH;
        dren_next  = 1'b0;
        dwen_next  = 1'b0;
      end
    endcase
  end

  assign rf_wen_en = pc_en;
  assign fsm_state = state;

endmodule
